// File: rtl/lsu_bus_master_if.sv
// Load/store pipeline and data-bus signals of the LSU bus master.
// The master modport is the LSU's view; slave is the pipeline plus memory responder.
interface lsu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output req_ready, resp_valid, resp_rdata, exc_adel, exc_ades, bus_err,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  req_ready, resp_valid, resp_rdata, exc_adel, exc_ades, bus_err,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/lsu_bus_master.sv
// One-at-a-time load/store initiator: alignment check, byte-lane bus request, load extension.
// req_ready only in IDLE; bus_req in T+1 after accept, response one cycle after gnt/rvalid, bus timeout.
module lsu_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    lsu_bus_master_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_next;
    logic        r_we, r_signed, r_adel, r_ades, r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_rdata, r_cnt;

    logic        w_in_word, w_in_half, w_misalign, w_timeout;
    logic [31:0] w_cnt_inc, w_load_data;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;

    assign w_in_word  = (bus.req_size == 2'b00) || (bus.req_size == 2'b11);
    assign w_in_half  = (bus.req_size == 2'b01);
    assign w_misalign = (w_in_word && (bus.req_addr[1:0] != 2'b00)) ||
                        (w_in_half && bus.req_addr[0]);
    assign w_cnt_inc  = r_cnt + 32'd1;
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TIMEOUT_CYCLES);

    always_comb begin
        w_lane_b = bus.bus_rdata[7:0];
        case (r_addr[1:0])
            2'd1:    w_lane_b = bus.bus_rdata[15:8];
            2'd2:    w_lane_b = bus.bus_rdata[23:16];
            2'd3:    w_lane_b = bus.bus_rdata[31:24];
            default: w_lane_b = bus.bus_rdata[7:0];
        endcase
        w_lane_h = r_addr[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (r_size)
            2'b01:   w_load_data = {{16{r_signed & w_lane_h[15]}}, w_lane_h};
            2'b10:   w_load_data = {{24{r_signed & w_lane_b[7]}}, w_lane_b};
            default: w_load_data = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.exc_adel   = 1'b0;
        bus.exc_ades   = 1'b0;
        bus.bus_err    = 1'b0;
        bus.bus_req    = 1'b0;
        bus.bus_we     = 1'b0;
        bus.bus_addr   = 32'd0;
        bus.bus_be     = 4'd0;
        bus.bus_wdata  = 32'd0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) w_next = w_misalign ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                bus.bus_req  = 1'b1;
                bus.bus_we   = r_we;
                bus.bus_addr = {r_addr[31:2], 2'b00};
                case (r_size)
                    2'b01: begin
                        bus.bus_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                        bus.bus_wdata = {2{r_wdata[15:0]}};
                    end
                    2'b10: begin
                        bus.bus_be    = 4'b0001 << r_addr[1:0];
                        bus.bus_wdata = {4{r_wdata[7:0]}};
                    end
                    default: begin
                        bus.bus_be    = 4'b1111;
                        bus.bus_wdata = r_wdata;
                    end
                endcase
                if (bus.bus_gnt)  w_next = r_we ? S_RESP : S_WAIT;
                else if (w_timeout) w_next = S_RESP;
            end
            S_WAIT: begin
                if (bus.bus_rvalid || w_timeout) w_next = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.exc_adel   = r_adel;
                bus.exc_ades   = r_ades;
                bus.bus_err    = r_err;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.resp_rdata = r_rdata;

    // Result data is only rewritten on the edge that enters RESP, so it holds between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we <= 1'b0; r_signed <= 1'b0; r_size <= 2'b00;
            r_addr <= 32'd0; r_wdata <= 32'd0; r_rdata <= 32'd0; r_cnt <= 32'd0;
            r_adel <= 1'b0; r_ades <= 1'b0; r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    r_we     <= bus.req_we;
                    r_size   <= bus.req_size;
                    r_signed <= bus.req_signed;
                    r_addr   <= bus.req_addr;
                    r_wdata  <= bus.req_wdata;
                    r_cnt    <= 32'd0;
                    r_adel   <= w_misalign & ~bus.req_we;
                    r_ades   <= w_misalign & bus.req_we;
                    r_err    <= 1'b0;
                    if (w_misalign) r_rdata <= 32'd0;
                end
                S_ISSUE: begin
                    r_cnt <= w_cnt_inc;
                    if (bus.bus_gnt) begin
                        if (r_we) r_rdata <= 32'd0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (bus.bus_rvalid) begin
                        r_rdata <= w_load_data;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed plus randomized bench for lsu_bus_master against a byte-arithmetic reference model.
module tb_lsu_bus_master;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] last_rdata;

    lsu_bus_master_if bus_if ();
    lsu_bus_master #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b01) ? 2 : (size == 2'b10) ? 1 : 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        int n = nbytes(size);
        return 4'(((1 << n) - 1) << addr[1:0]);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] o;
        int n = nbytes(size);
        for (int k = 0; k < 4; k++) o[8*k +: 8] = wd[8*(k % n) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [31:0] addr, input logic [31:0] rd);
        int n = nbytes(size);
        logic [31:0] v, mask;
        v = rd >> (8 * int'(addr[1:0]));
        if (n == 4) return rd;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = v & mask;
        if (sgn && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                           input int gdly, input int rdly);
        logic        mis;
        logic [31:0] erd;
        mis = (int'(addr[1:0]) % nbytes(size)) != 0;
        erd = 32'd0;
        bus_if.req_valid = 1'b1; bus_if.req_we = we; bus_if.req_size = size;
        bus_if.req_signed = sgn; bus_if.req_addr = addr; bus_if.req_wdata = wdata;
        chk({tag, "/ready"}, bus_if.req_ready, 1);
        tick();
        bus_if.req_valid = 1'b0; bus_if.req_addr = $urandom; bus_if.req_wdata = $urandom;
        bus_if.req_size = 2'($urandom); bus_if.req_we = 1'($urandom);
        if (mis) begin
            chk({tag, "/mis_resp"}, bus_if.resp_valid, 1);
            chk({tag, "/mis_flags"}, {bus_if.exc_adel, bus_if.exc_ades, bus_if.bus_err}, {~we, we, 1'b0});
            chk({tag, "/mis_busreq"}, bus_if.bus_req, 0);
            chk({tag, "/mis_rdata"}, bus_if.resp_rdata, 0);
        end else begin
            for (int i = 0; i <= gdly; i++) begin
                chk({tag, "/req"}, bus_if.bus_req, 1);
                chk({tag, "/addr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
                chk({tag, "/be"}, bus_if.bus_be, model_be(size, addr));
                chk({tag, "/we"}, bus_if.bus_we, we);
                if (we) chk({tag, "/wdata"}, bus_if.bus_wdata, model_wdata(size, wdata));
                chk({tag, "/early_resp"}, bus_if.resp_valid, 0);
                if (i == gdly) bus_if.bus_gnt = 1'b1;
                tick();
            end
            bus_if.bus_gnt = 1'b0;
            if (!we) begin
                for (int i = 0; i <= rdly; i++) begin
                    chk({tag, "/wait_req"}, bus_if.bus_req, 0);
                    chk({tag, "/wait_resp"}, bus_if.resp_valid, 0);
                    if (i == rdly) begin
                        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = rdata;
                    end else bus_if.bus_rdata = $urandom;
                    tick();
                end
                bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = $urandom;
                erd = model_load(size, sgn, addr, rdata);
            end
            chk({tag, "/resp"}, bus_if.resp_valid, 1);
            chk({tag, "/flags"}, {bus_if.exc_adel, bus_if.exc_ades, bus_if.bus_err}, 0);
            chk({tag, "/resp_busreq"}, bus_if.bus_req, 0);
            chk({tag, "/rdata"}, bus_if.resp_rdata, erd);
        end
        last_rdata = bus_if.resp_rdata;
        tick();
        chk({tag, "/pulse_end"}, bus_if.resp_valid, 0);
        chk({tag, "/idle_ready"}, bus_if.req_ready, 1);
        chk({tag, "/idle_flags"}, {bus_if.exc_adel, bus_if.exc_ades, bus_if.bus_err}, 0);
        chk({tag, "/rdata_hold"}, bus_if.resp_rdata, erd);
    endtask

    initial begin
        int n;
        bus_if.req_valid = 0; bus_if.req_we = 0; bus_if.req_size = 0; bus_if.req_signed = 0;
        bus_if.req_addr = 0; bus_if.req_wdata = 0;
        bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/ready", bus_if.req_ready, 1);
        chk("rst/outs", {bus_if.resp_valid, bus_if.exc_adel, bus_if.exc_ades, bus_if.bus_err,
                         bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}, 0);
        chk("rst/addr", bus_if.bus_addr, 0);
        chk("rst/wdata", bus_if.bus_wdata, 0);
        chk("rst/rdata", bus_if.resp_rdata, 0);
        reset = 1'b0;
        tick();

        run_txn("sb", 1, 2'b10, 0, 32'h0000_1003, 32'h1234_5678, 0, 2, 0);
        run_txn("lh", 0, 2'b01, 1, 32'h0000_1002, 0, 32'h8001_7FFF, 1, 1);
        chk("lh/const", last_rdata, 32'hFFFF_8001);
        run_txn("lhu", 0, 2'b01, 0, 32'h0000_1002, 0, 32'h8001_7FFF, 0, 0);
        chk("lhu/const", last_rdata, 32'h0000_8001);
        run_txn("lb", 0, 2'b10, 1, 32'h0000_1001, 0, 32'h0000_8000, 0, 2);
        chk("lb/const", last_rdata, 32'hFFFF_FF80);
        run_txn("lbu", 0, 2'b10, 0, 32'h0000_1001, 0, 32'h0000_8000, 1, 0);
        chk("lbu/const", last_rdata, 32'h0000_0080);
        run_txn("lw", 0, 2'b00, 1, 32'h0000_1000, 0, 32'hCAFE_F00D, 2, 2);
        chk("lw/const", last_rdata, 32'hCAFE_F00D);
        run_txn("lw_mis", 0, 2'b00, 0, 32'h0000_1002, 0, 0, 0, 0);
        run_txn("sh_mis", 1, 2'b01, 0, 32'h0000_1001, 32'h5555_AAAA, 0, 0, 0);
        run_txn("sw11", 1, 2'b11, 0, 32'h0000_2004, 32'h0BAD_BEEF, 0, 1, 0);

        for (int t = 0; t < 40; t++) begin
            run_txn($sformatf("rnd%0d", t), 1'($urandom), 2'($urandom), 1'($urandom),
                    32'h0000_4000 + 32'($urandom_range(0, 255)), $urandom, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2));
        end

        bus_if.req_valid = 1; bus_if.req_we = 0; bus_if.req_size = 2'b00; bus_if.req_addr = 32'h0000_5000;
        tick();
        bus_if.req_valid = 0;
        n = 0;
        while (bus_if.bus_req && n < 20) begin
            n++;
            tick();
        end
        chk("to/req_cycles", n, 8);
        chk("to/resp", bus_if.resp_valid, 1);
        chk("to/err", {bus_if.exc_adel, bus_if.exc_ades, bus_if.bus_err}, 3'b001);
        chk("to/rdata", bus_if.resp_rdata, 0);
        bus_if.bus_gnt = 1; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h1111_2222;
        tick();
        chk("to/late_ready", bus_if.req_ready, 1);
        chk("to/late_resp", bus_if.resp_valid, 0);
        chk("to/late_req", bus_if.bus_req, 0);
        tick();
        chk("to/late_resp2", bus_if.resp_valid, 0);
        bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0;

        bus_if.req_valid = 1; bus_if.req_we = 0; bus_if.req_size = 2'b00; bus_if.req_addr = 32'h0000_3000;
        tick();
        bus_if.req_valid = 0;
        chk("rw/issue", bus_if.bus_req, 1);
        bus_if.bus_gnt = 1;
        tick();
        bus_if.bus_gnt = 0;
        chk("rw/wait", bus_if.bus_req, 0);
        reset = 1;
        tick();
        reset = 0;
        chk("rw/req", bus_if.bus_req, 0);
        chk("rw/resp", bus_if.resp_valid, 0);
        chk("rw/ready", bus_if.req_ready, 1);
        chk("rw/rdata", bus_if.resp_rdata, 0);
        bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_if.bus_rvalid = 0;
        chk("rw/stray1", bus_if.resp_valid, 0);
        tick();
        chk("rw/stray2", bus_if.resp_valid, 0);
        chk("rw/ready2", bus_if.req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store initiator between the MEM pipeline stage and the byte-lane data-memory responder.
- Accepts one load/store per handshake, checks alignment, and generates a word-aligned bus request with byte enables and lane-replicated write data.
- Waits for grant and, for loads, read data; extracts and sign- or zero-extends the addressed lane; returns a one-cycle response.
- Holds off further requests and enforces a bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in ISSUE+WAIT before the bus-error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  unit idle, can accept (= state==IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 WORD, 01 HALF, 10 BYTE, 11 treated as WORD
- req_signed  in  1  load sign-extend (ignored for WORD and stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for HALF/BYTE)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- exc_adel  out  1  misaligned load (valid with resp_valid)
- exc_ades  out  1  misaligned store (valid with resp_valid)
- bus_err  out  1  timeout (valid with resp_valid)
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_gnt  in  1  responder accepts request
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data

Behaviour:
- Reset:
  - state=IDLE; timeout counter=0.
  - All outputs 0 except req_ready=1.
  - resp_rdata cleared.
  - Reset mid-transaction abandons it: bus_req drops at that edge and no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_valid at a clock edge latches we/size/signed/addr/wdata.
  - Misaligned (WORD addr[1:0]!=0, HALF addr[0]!=0) -> RESP with exc_adel (load) or exc_ades (store); no bus activity.
  - Otherwise -> ISSUE.
- ISSUE:
  - bus_req=1; bus_we/addr/be/wdata stable until grant.
  - bus_gnt=1: store -> RESP; load -> WAIT.
- WAIT:
  - bus_req=0; bus_rvalid is sampled only here.
  - On rvalid, capture the lane, extend it, then -> RESP.
  - Responder asserts rvalid no earlier than the cycle after grant.
- RESP:
  - resp_valid=1 for exactly one cycle with its flags, then -> IDLE.
  - resp_rdata holds until the next response.
- Byte enables:
  - WORD: 1111.
  - HALF: addr[1]=0 -> 0011, addr[1]=1 -> 1100.
  - BYTE: 0001<<addr[1:0].
- Write data:
  - WORD: wdata.
  - HALF: {wdata[15:0],wdata[15:0]}.
  - BYTE: {4{wdata[7:0]}}.
- Load lanes are little-endian: byte k = rdata[8k+7:8k]; half addr[1] selects [15:0] or [31:16].
- Extension: signed replicates the lane MSB; unsigned zero-fills.
- Timeout:
  - Counter resets on entering ISSUE and increments each cycle in ISSUE/WAIT.
  - At count==TIMEOUT_CYCLES without completion -> RESP with bus_err=1, resp_rdata=0, bus_req deasserted.
  - A late gnt/rvalid arriving in IDLE/RESP is ignored.
- Latency:
  - Request accepted at edge T: bus_req high in cycle T+1.
  - Grant in cycle G: store resp_valid in cycle G+1.
  - Load rvalid in cycle R: resp_valid in cycle R+1.
  - Misaligned: resp_valid in cycle T+1.
- Exception flags are mutually exclusive, zero outside resp_valid.

Test Plan:
- sb addr 0x0000_1003, wdata 0x1234_5678, gnt 2 cycles after req -> bus_addr 0x1000, bus_be 1000, bus_wdata 0x7878_7878, bus_we 1; resp_valid one cycle after gnt, resp_rdata 0.
- lh signed addr 0x1002, bus_rdata 0x8001_7FFF -> resp_rdata 0xFFFF_8001, bus_be 1100; repeat as lhu -> 0x0000_8001.
- lb signed addr 0x1001, bus_rdata 0x0000_8000 -> 0xFFFF_FF80; lbu -> 0x0000_0080; lw addr 0x1000 -> full word unchanged.
- lw addr 0x1002 -> exc_adel=1, resp_valid in cycle T+1, bus_req never asserted; sh addr 0x1001 -> exc_ades=1, same behaviour.
- TIMEOUT_CYCLES=8, bus_gnt held 0 -> bus_req high 8 cycles, then bus_err=1 with resp_valid; gnt arriving afterwards ignored, req_ready=1.
- Load granted, reset asserted in WAIT -> next cycle bus_req=0, resp_valid=0, req_ready=1; subsequent stray bus_rvalid produces no response.
